mem_burst_master: RTL

Initiator-side controller for the single-cycle memory slave port (wen/ren/addr/wdata/rdata) used by the slave memories in the system bus. It accepts one burst request at a time over a valid/ready handshake. It converts the request into a sequence of single-beat memory accesses at incrementing addresses. Write data is taken from an input stream and read data is returned on a backpressured output stream. It sits between a bus master adapter or test harness and any slave memory instance.

---
 rtl/mem_burst_if.sv | 36 +++
 rtl/mem_burst_master.sv | 73 +++++++
 2 files changed

// File: rtl/mem_burst_if.sv
// mem_burst_if: request, write/read streams and memory port of the burst master.
interface mem_burst_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  done;
  logic                  busy;
  logic                  mem_wen;
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready, mem_rdata,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy,
           mem_wen, mem_ren, mem_addr, mem_wdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready, mem_rdata,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy,
           mem_wen, mem_ren, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_burst_master.sv
// mem_burst_master: turns one burst request into single-beat accesses on a
// single-cycle memory port, with a streamed write input and backpressured read output.
module mem_burst_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input logic        clk,
  input logic        rst,
  mem_burst_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH:0]    beats_left;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid, rd_last, wen, ren, pop, last_beat;
  assign last_beat = beats_left == (LEN_WIDTH+1)'(1);
  assign pop = rd_valid & bus.rd_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = bus.req_write ? WRITE : READ;
      WRITE:   if (wen && last_beat) state_nxt = DONE;
      READ:    if (ren && last_beat) state_nxt = DRAIN;
      DRAIN:   if (pop && rd_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // A read may issue whenever the output register is empty or being emptied this cycle.
  always_comb begin
    wen           = state == WRITE && bus.wr_valid;
    ren           = state == READ && (!rd_valid || bus.rd_ready);
    bus.req_ready = state == IDLE;
    bus.busy      = state != IDLE;
    bus.done      = state == DONE;
    bus.wr_ready  = wen;
    bus.mem_wen   = wen;
    bus.mem_ren   = ren;
    bus.mem_addr  = (wen || ren) ? cur_addr : '0;
    bus.mem_wdata = wen ? bus.wr_data : '0;
    bus.rd_valid  = rd_valid;
    bus.rd_data   = rd_data;
    bus.rd_last   = rd_last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur_addr   <= '0;
      beats_left <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        cur_addr   <= bus.req_addr;
        beats_left <= {1'b0, bus.req_len} + 1'b1;
      end else if (wen || ren) begin
        cur_addr   <= cur_addr + 1'b1;
        beats_left <= beats_left - 1'b1;
      end
      if (ren) begin
        rd_data  <= bus.mem_rdata;
        rd_valid <= 1'b1;
        rd_last  <= last_beat;
      end else if (pop) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
endmodule
